// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared defaults and FSM state type for the scope capture block
//
// Purpose : default sizing for the capture buffer and the capture FSM state enum.
// Ports   : none (package).
package scope_pkg;

    localparam int DEF_DATA_W  = 12;
    localparam int DEF_DEPTH   = 512;
    localparam int DEF_ADDR_W  = $clog2(DEF_DEPTH);
    localparam int DEF_PRETRIG = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/scope_ram.sv
// rtl/scope_ram.sv - simple dual-port sample buffer with registered read
//
// Purpose : DEPTH x DATA_W storage, one write port, one registered read port.
// Ports   : clk                       clock
//           wr_en, wr_addr, wr_data   write port
//           rd_addr                   read address
//           rd_data                   read data, one clk after rd_addr
module scope_ram
    import scope_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array or read register so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/scope_capture.sv
// rtl/scope_capture.sv - triggered waveform capture of a sample stream into a circular buffer
//
// Purpose : records DEPTH accepted samples around a level-crossing trigger, with
//           PRETRIG samples ahead of the trigger sample, then holds them for readout.
// Ports   : clk, reset                          clock, synchronous active-high reset
//           ast_sink_data/valid/error           sample stream (no backpressure)
//           arm                                 pulse: start/restart a capture
//           trig_level, trig_slope              threshold, 0 rising / 1 falling
//           rd_addr, rd_data                    logical readout, 0 = oldest sample
//           busy, done, err_seen                status
module scope_capture
    import scope_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PRETRIG = DEF_PRETRIG,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ast_sink_data,
    input  logic              ast_sink_valid,
    input  logic [1:0]        ast_sink_error,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err_seen
);

    // Samples that follow the trigger sample to complete the capture.
    localparam int POST_LEN = DEPTH - PRETRIG - 1;
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(PRETRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_LEN > 0) ? (POST_LEN - 1) : 0);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] trig_ptr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] rd_phys;
    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] ram_q;
    logic              prev_valid_q;
    logic              err_seen_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              bad;
    logic              capturing;
    logic              wr_en;
    logic              trig_hit;

    // Sample qualification and trigger compare.
    always_comb begin
        accept    = ast_sink_valid && (ast_sink_error == 2'b00);
        bad       = ast_sink_valid && (ast_sink_error != 2'b00);
        capturing = (state_q == FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
        // arm takes priority: a sample arriving with arm is dropped.
        wr_en     = capturing && accept && !arm;
        if (trig_slope) begin
            trig_hit = prev_valid_q && (prev_q > trig_level) && (ast_sink_data <= trig_level);
        end else begin
            trig_hit = prev_valid_q && (prev_q < trig_level) && (ast_sink_data >= trig_level);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept && (cnt_q == FILL_LAST)) begin
                        state_d = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    // Triggers only here, so a crossing inside the pre-trigger fill is ignored.
                    if (accept && trig_hit) begin
                        state_d = (POST_LEN == 0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (accept && (cnt_q == POST_LAST)) begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Logical index 0 is PRETRIG samples ahead of the trigger; ADDR_W-wide math wraps mod DEPTH.
    always_comb begin
        rd_phys = trig_ptr_q - PRE_OFS + rd_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            trig_ptr_q   <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            err_seen_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= capturing;
            done_q  <= (state_q == DONE);
            if (arm) begin
                wr_ptr_q     <= '0;
                cnt_q        <= '0;
                prev_valid_q <= 1'b0;
                err_seen_q   <= 1'b0;
            end else begin
                if (capturing && bad) begin
                    err_seen_q <= 1'b1;
                end
                if (wr_en) begin
                    wr_ptr_q     <= wr_ptr_q + 1'b1;
                    prev_q       <= ast_sink_data;
                    prev_valid_q <= 1'b1;
                    case (state_q)
                        FILL: begin
                            cnt_q <= (cnt_q == FILL_LAST) ? '0 : cnt_q + 1'b1;
                        end
                        WAIT_TRIG: begin
                            if (trig_hit) begin
                                trig_ptr_q <= wr_ptr_q;
                                cnt_q      <= '0;
                            end
                        end
                        POST: begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        default: begin
                            cnt_q <= cnt_q;
                        end
                    endcase
                end
            end
        end
    end

    scope_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (ast_sink_data),
        .rd_addr (rd_phys),
        .rd_data (ram_q)
    );

    // done_q tracks the DONE state one clk late, in step with the registered RAM read.
    assign rd_data  = done_q ? ram_q : '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_seen = err_seen_q;

endmodule

// File: tb/tb_scope_capture.sv
// tb/tb_scope_capture.sv - self-checking bench for scope_capture
module tb_scope_capture;

    localparam int DW      = 12;
    localparam int DEPTH   = 512;
    localparam int AW      = 9;
    localparam int PRETRIG = 64;
    localparam int POSTN   = DEPTH - PRETRIG - 1;

    localparam int M_RAMP8 = 0;
    localparam int M_FALL  = 1;
    localparam int M_FILLX = 2;
    localparam int M_ERR   = 3;
    localparam int M_WRAP  = 4;
    localparam int M_RAND  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] ast_sink_data;
    logic          ast_sink_valid;
    logic [1:0]    ast_sink_error;
    logic          arm;
    logic [DW-1:0] trig_level;
    logic          trig_slope;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          err_seen;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic          m_err;
    int            last_post_slots;

    typedef struct {
        int          grp;
        int          addr;
        logic [11:0] exp;
    } rvec_t;
    rvec_t tab[13];

    scope_capture dut (
        .clk            (clk),
        .reset          (reset),
        .ast_sink_data  (ast_sink_data),
        .ast_sink_valid (ast_sink_valid),
        .ast_sink_error (ast_sink_error),
        .arm            (arm),
        .trig_level     (trig_level),
        .trig_slope     (trig_slope),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .err_seen       (err_seen)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: first index >= PRETRIG where the accepted-sample list crosses the level.
    function automatic int model_trig(input logic [DW-1:0] lvl, input logic slp);
        for (int i = PRETRIG; i < q.size(); i++) begin
            if (!slp && (q[i-1] < lvl) && (q[i] >= lvl)) return i;
            if (slp && (q[i-1] > lvl) && (q[i] <= lvl)) return i;
        end
        return -1;
    endfunction

    task automatic slot(input logic [DW-1:0] d, input logic v, input logic [1:0] e, input logic a);
        ast_sink_data  = d;
        ast_sink_valid = v;
        ast_sink_error = e;
        arm            = a;
        tick();
        if (a) begin
            q.delete();
            m_err = 1'b0;
        end else if (v && (e == 2'b00)) begin
            q.push_back(d);
        end else if (v) begin
            m_err = 1'b1;
        end
        ast_sink_valid = 1'b0;
        ast_sink_error = 2'b00;
        arm            = 1'b0;
    endtask

    task automatic apply_tab(input int grp, input string tag);
        for (int i = 0; i < 13; i++) begin
            if (tab[i].grp == grp) begin
                rd_addr = AW'(tab[i].addr);
                tick();
                chk($sformatf("%s_tab_rd%0d", tag, tab[i].addr), 32'(rd_data), 32'(tab[i].exp));
            end
        end
    endtask

    task automatic run_capture(input int mode, input logic [DW-1:0] lvl, input logic slp,
                               input int gap, input int max_slots, input logic arm_smp,
                               input string tag);
        logic          got_done;
        logic [DW-1:0] d;
        logic          v;
        logic [1:0]    e;
        int            n, t, walk, inj, idle;
        trig_level = lvl;
        trig_slope = slp;
        slot(12'h777, arm_smp, 2'b00, 1'b1);
        chk({tag, "_errclr"}, 32'(err_seen), 32'd0);
        for (int g = 1; g < gap; g++) tick();
        got_done        = 1'b0;
        walk            = 'h800;
        inj             = 0;
        last_post_slots = 0;
        for (int k = 0; k < max_slots && !got_done; k++) begin
            n = q.size();
            t = model_trig(lvl, slp);
            v = 1'b1;
            e = 2'b00;
            case (mode)
                M_RAMP8: d = DW'(8 * n);
                M_FALL:  d = DW'('hFFC - 4 * n);
                M_FILLX: d = (n == 9 || n == 100) ? 12'h500 :
                             (n < 100) ? 12'h100 : DW'($urandom);
                M_ERR: begin
                    d = DW'(n);
                    if ((n == 350 && inj == 0) || (n == 400 && inj == 1) || (n == 450 && inj == 2)) begin
                        d = 12'hABC;
                        e = 2'b01;
                        inj++;
                    end
                end
                M_WRAP:  d = DW'(n);
                default: begin
                    walk = walk + int'($urandom_range(0, 128)) - 64;
                    if (walk < 0) walk = 0;
                    if (walk > 'hFFF) walk = 'hFFF;
                    d = DW'(walk);
                    v = ($urandom_range(0, 7) != 0);
                    e = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                end
            endcase
            slot(d, v, e, 1'b0);
            if (t >= 0 && v) last_post_slots++;
            if (done) got_done = 1'b1;
            if (k == 5) begin
                rd_addr = AW'($urandom);
                chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
                chk({tag, "_done_mid"}, 32'(done), 32'd0);
                chk({tag, "_rd0_mid"}, 32'(rd_data), 32'd0);
            end
            idle = gap + ((mode == M_RAND) ? int'($urandom_range(0, 2)) : 0);
            for (int g = 1; g < idle; g++) begin
                tick();
                if (done) got_done = 1'b1;
            end
        end
        chk({tag, "_done"}, 32'(got_done), 32'd1);
        t = model_trig(lvl, slp);
        chk({tag, "_trig_found"}, 32'(t >= 0), 32'd1);
        if (t >= 0) begin
            chk({tag, "_post_count"}, 32'(q.size() - t - 1), 32'(POSTN));
            chk({tag, "_err_seen"}, 32'(err_seen), 32'(m_err));
            for (int a = 0; a < DEPTH; a++) begin
                rd_addr = AW'(a);
                tick();
                if (t - PRETRIG + a < q.size())
                    chk($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(q[t - PRETRIG + a]));
            end
        end
    endtask

    initial begin
        tab[0]  = '{0, 64,  12'h400};
        tab[1]  = '{0, 63,  12'h3F8};
        tab[2]  = '{0, 0,   12'h200};
        tab[3]  = '{0, 65,  12'h408};
        tab[4]  = '{0, 511, 12'h1F8};
        tab[5]  = '{1, 64,  12'h800};
        tab[6]  = '{1, 63,  12'h804};
        tab[7]  = '{1, 0,   12'h900};
        tab[8]  = '{1, 511, 12'h104};
        tab[9]  = '{2, 0,   12'h1B4};
        tab[10] = '{2, 64,  12'h1F4};
        tab[11] = '{2, 511, 12'h3B3};
        tab[12] = '{2, 12,  12'h1C0};

        reset          = 1'b1;
        ast_sink_data  = '0;
        ast_sink_valid = 1'b0;
        ast_sink_error = 2'b00;
        arm            = 1'b0;
        trig_level     = '0;
        trig_slope     = 1'b0;
        rd_addr        = '0;
        m_err          = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_seen), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);

        // Rising ramp step 8, one sample every 20 clks.
        run_capture(M_RAMP8, 12'h400, 1'b0, 20, 700, 1'b0, "ramp");
        apply_tab(0, "ramp");

        // Falling ramp step -4.
        run_capture(M_FALL, 12'h800, 1'b1, 3, 1100, 1'b0, "fall");
        apply_tab(1, "fall");

        // Crossing inside the pre-trigger fill must not trigger.
        run_capture(M_FILLX, 12'h400, 1'b0, 3, 700, 1'b0, "fillx");
        rd_addr = AW'(64);
        tick();
        chk("fillx_trig_val", 32'(rd_data), 32'h500);

        // Errored samples in POST.
        run_capture(M_ERR, 12'd300, 1'b0, 3, 900, 1'b0, "errpost");
        chk("errpost_err_seen_set", 32'(err_seen), 32'd1);
        chk("errpost_slots", 32'(last_post_slots), 32'(POSTN + 3));

        // Trigger at physical 500, buffer wraps.
        run_capture(M_WRAP, 12'd500, 1'b0, 2, 1100, 1'b0, "wrap");
        apply_tab(2, "wrap");

        // Reset during POST.
        trig_level = 12'd500;
        trig_slope = 1'b0;
        slot(12'h000, 1'b0, 2'b00, 1'b1);
        for (int k = 0; k < 600; k++) begin
            slot(DW'(k), 1'b1, 2'b00, 1'b0);
            tick();
        end
        rd_addr = AW'(64);
        chk("prerst_busy", 32'(busy), 32'd1);
        chk("prerst_rd", 32'(rd_data), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rd", 32'(rd_data), 32'd0);
        repeat (3) tick();
        chk("midrst_rd_idle", 32'(rd_data), 32'd0);

        // Arm together with a valid sample: that sample is dropped.
        run_capture(M_WRAP, 12'd500, 1'b0, 2, 1100, 1'b1, "armsmp");
        apply_tab(2, "armsmp");

        // Randomised captures.
        for (int r = 0; r < 3; r++) begin
            run_capture(M_RAND, 12'h800 + DW'($urandom_range(0, 64)) - 12'd32,
                        1'($urandom), 2, 3000, 1'($urandom), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
